// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared SPI definitions for the slave and its sibling spi_master.
//   SPI_DATA_WIDTH : default word length in bits
//   SPI_CPOL/CPHA  : bus mode (mode 0: sclk idles low, data sampled on rise)
//   spi_state_e    : slave frame FSM states
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 16;
  localparam bit SPI_CPOL       = 1'b0;
  localparam bit SPI_CPHA       = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// ---------------------------------------------------------------------------
// spi_slave_if
// Bundles the SPI pad signals and the internal tx/rx word handshake.
//   slave  modport : view of the spi_slave block
//   master modport : view of whoever drives the pads and consumes words
// Optional port rx_frame_err exists only when SPI_SLAVE_FRAME_ERR_EN is
// defined.
// ---------------------------------------------------------------------------
interface spi_slave_if #(
  parameter int DATA_WIDTH = spi_pkg::SPI_DATA_WIDTH
);

  logic                  s_sclk;
  logic                  s_csn;
  logic                  s_mosi;
  logic                  s_miso;
  logic                  s_miso_oe;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  tx_underrun;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic                  rx_frame_err;
`endif

  modport slave (
    input  s_sclk, s_csn, s_mosi, tx_data, tx_valid,
    output s_miso, s_miso_oe, tx_ready, rx_data, rx_valid, tx_underrun
`ifdef SPI_SLAVE_FRAME_ERR_EN
    , output rx_frame_err
`endif
  );

  modport master (
    output s_sclk, s_csn, s_mosi, tx_data, tx_valid,
    input  s_miso, s_miso_oe, tx_ready, rx_data, rx_valid, tx_underrun
`ifdef SPI_SLAVE_FRAME_ERR_EN
    , input rx_frame_err
`endif
  );

endinterface

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// Multi-flop synchronizer for an asynchronous input followed by an edge
// detector on the synchronized level.
//   clk, reset : system clock, synchronous active-high reset
//   async_in   : asynchronous input
//   rise, fall : one-cycle pulses on synchronized edges
// All flops reset to 0, so a line that is already low when reset releases
// produces no falling-edge pulse.
// ---------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
// SPI mode-0, MSB-first slave oversampled in the clk domain.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : spi_slave_if.slave (pads s_sclk/s_csn/s_mosi/s_miso/
//                s_miso_oe, one-deep tx buffer tx_data/tx_valid/tx_ready,
//                rx_data/rx_valid, tx_underrun pulse)
// Optional feature macro SPI_SLAVE_FRAME_ERR_EN adds rx_frame_err, a pulse
// for a frame that ends mid-word.
// SPI clock phases must each last at least SYNC_STAGES+2 clk cycles.
// ---------------------------------------------------------------------------
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input logic        clk,
  input logic        reset,
  spi_slave_if.slave bus
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_rise, sclk_fall, csn_rise, csn_fall;

  spi_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-2:0]  rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   tx_underrun_q, tx_underrun_d;
  logic [DATA_WIDTH-1:0]  buf_q, buf_d;
  logic                   buf_full_q, buf_full_d;
  logic                   word_done_q, word_done_d;
  logic                   miso_oe_q, miso_oe_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [DATA_WIDTH-1:0]  rx_word;
  logic                   load_now;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic                   frame_err_q, frame_err_d;
`endif

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (bus.s_sclk),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_csn_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (bus.s_csn),
    .rise     (csn_rise),
    .fall     (csn_fall)
  );

  // mosi shares the sclk synchronizer depth, so data and its sampling edge
  // arrive in the clk domain with identical latency.
  assign rx_word = {rx_shift_q, mosi_sync_q[SYNC_STAGES-1]};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    buf_d         = buf_q;
    buf_full_d    = buf_full_q;
    word_done_d   = word_done_q;
    miso_oe_d     = miso_oe_q;
    mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], bus.s_mosi};
    load_now      = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    frame_err_d   = 1'b0;
`endif

    // Output enable follows csn edges rather than the raw level, so a frame
    // interrupted by reset stays quiet until csn is cycled.
    if (csn_fall) miso_oe_d = 1'b1;

    case (state_q)
      IDLE: if (csn_fall) state_d = LOAD;
      LOAD: begin
        load_now    = 1'b1;
        cnt_d       = '0;
        word_done_d = 1'b0;
        state_d     = SHIFT;
      end
      SHIFT: begin
        if (sclk_rise) begin
          rx_shift_d = rx_word[DATA_WIDTH-2:0];
          if (cnt_q == LAST_BIT) begin
            rx_data_d   = rx_word;
            rx_valid_d  = 1'b1;
            cnt_d       = '0;
            word_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          // The falling edge after a completed word starts the next one.
          if (word_done_q) begin
            word_done_d = 1'b0;
            load_now    = 1'b1;
          end else begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A csn_rise coinciding with a reload edge ends the frame instead, so
    // the buffered word is kept for the next frame.
    if (load_now && !csn_rise) begin
      if (buf_full_q) begin
        tx_shift_d = buf_q;
        buf_full_d = 1'b0;
      end else begin
        tx_shift_d    = '0;
        tx_underrun_d = 1'b1;
      end
    end

    // Handshake only possible while empty, so it never races a buffer load.
    if (bus.tx_valid && !buf_full_q) begin
      buf_d      = bus.tx_data;
      buf_full_d = 1'b1;
    end

    // Frame end wins over everything except a word completing this cycle.
    if (csn_rise) begin
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_d = (cnt_d != '0);
`endif
      state_d     = IDLE;
      cnt_d       = '0;
      word_done_d = 1'b0;
      tx_shift_d  = '0;
      miso_oe_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      buf_q         <= '0;
      buf_full_q    <= 1'b0;
      word_done_q   <= 1'b0;
      miso_oe_q     <= 1'b0;
      mosi_sync_q   <= '0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      buf_q         <= buf_d;
      buf_full_q    <= buf_full_d;
      word_done_q   <= word_done_d;
      miso_oe_q     <= miso_oe_d;
      mosi_sync_q   <= mosi_sync_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_q   <= frame_err_d;
`endif
    end
  end

  // s_miso is the shifter MSB, which is cleared whenever the frame ends.
  assign bus.s_miso      = tx_shift_q[DATA_WIDTH-1];
  assign bus.s_miso_oe   = miso_oe_q;
  assign bus.tx_ready    = ~buf_full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = tx_underrun_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  assign bus.rx_frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave
// Drives spi_slave as an SPI mode-0 master and checks words in both
// directions against a word-level model of the one-deep tx buffer.
// Honours SPI_SLAVE_FRAME_ERR_EN when defined.
// ---------------------------------------------------------------------------
module tb_spi_slave;

  localparam int DW   = 16;
  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] rx_q[$];
  int            rx_pulses       = 0;
  int            underrun_pulses = 0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  int            frame_err_pulses = 0;
  int            exp_frame_err    = 0;
`endif

  // Word-level reference model
  logic [DW-1:0] m_buf         = '0;
  bit            m_full        = 1'b0;
  int            exp_rx        = 0;
  int            exp_underruns = 0;
  logic [DW-1:0] exp_last_rx   = '0;

  always #5 clk = ~clk;

  spi_slave_if #(.DATA_WIDTH(DW)) bus ();

  spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Record output pulses away from the active edge
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      rx_q.push_back(bus.rx_data);
      rx_pulses++;
    end
    if (bus.tx_underrun === 1'b1) underrun_pulses++;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    if (bus.rx_frame_err === 1'b1) frame_err_pulses++;
`endif
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Model of a word starting: buffer content, or zeros plus an underrun
  function automatic logic [DW-1:0] model_load();
    if (m_full) begin
      m_full = 1'b0;
      return m_buf;
    end
    exp_underruns++;
    return '0;
  endfunction

  task automatic push_tx(input logic [DW-1:0] w);
    bit done;
    done = 1'b0;
    repeat (4) @(negedge clk);
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (bus.tx_ready === 1'b1) done = 1'b1;
      @(negedge clk);
    end
    bus.tx_valid = 1'b0;
    checkOutput("push_tx_accept", 32'(done), 32'd1);
    checkOutput("push_tx_ready_low", 32'(bus.tx_ready), 32'd0);
    m_buf  = w;
    m_full = 1'b1;
  endtask

  task automatic csn_low();
    @(negedge clk);
    bus.s_csn = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  // Shift nbits MSB-first; optionally end the frame on the last falling edge
  task automatic applyStimulus(input logic [DW-1:0] mosi_w, input int nbits,
                               input bit end_frame, output logic [DW-1:0] miso_w);
    miso_w = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.s_mosi = mosi_w[DW-1-i];
      repeat (HALF) @(negedge clk);
      bus.s_sclk = 1'b1;
      miso_w[DW-1-i] = bus.s_miso;
      repeat (HALF) @(negedge clk);
      bus.s_sclk = 1'b0;
      if (end_frame && i == nbits - 1) bus.s_csn = 1'b1;
    end
    if (end_frame) repeat (3 * HALF) @(negedge clk);
  endtask

  task automatic check_rx(input string tag, input logic [DW-1:0] expw);
    logic [31:0] got;
    if (rx_q.size() > 0) got = {16'h0, rx_q.pop_front()};
    else got = 32'hFFFF_FFFF;
    checkOutput(tag, got, {16'h0, expw});
  endtask

  task automatic send_word(input string tag, input logic [DW-1:0] mosi_w,
                           input bit end_frame, input bit do_push,
                           input logic [DW-1:0] push_w);
    logic [DW-1:0] exp_miso;
    logic [DW-1:0] got;
    exp_miso = model_load();
    if (do_push) push_tx(push_w);
    applyStimulus(mosi_w, DW, end_frame, got);
    checkOutput({tag, "_miso"}, {16'h0, got}, {16'h0, exp_miso});
    exp_rx++;
    exp_last_rx = mosi_w;
    check_rx({tag, "_rx"}, mosi_w);
  endtask

  initial begin
    logic [DW-1:0] e;
    logic [DW-1:0] g;
    int            nw;

    bus.s_sclk   = 1'b0;
    bus.s_csn    = 1'b1;
    bus.s_mosi   = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    repeat (4) @(negedge clk);

    // Reset state
    checkOutput("rst_miso", 32'(bus.s_miso), 32'd0);
    checkOutput("rst_oe", 32'(bus.s_miso_oe), 32'd0);
    checkOutput("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    checkOutput("rst_rx_data", 32'(bus.rx_data), 32'd0);
    checkOutput("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    checkOutput("rst_underrun", 32'(bus.tx_underrun), 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // Single word
    push_tx(16'h3C5A);
    csn_low();
    checkOutput("t1_oe_active", 32'(bus.s_miso_oe), 32'd1);
    send_word("t1", 16'hA5C3, 1'b1, 1'b0, '0);
    checkOutput("t1_tx_ready", 32'(bus.tx_ready), 32'd1);
    checkOutput("t1_oe_idle", 32'(bus.s_miso_oe), 32'd0);
    checkOutput("t1_rx_count", rx_pulses, exp_rx);

    // Back-to-back words
    push_tx(16'h1111);
    csn_low();
    send_word("t2a", 16'hBEEF, 1'b0, 1'b1, 16'h2222);
    send_word("t2b", 16'hCAFE, 1'b1, 1'b0, '0);
    checkOutput("t2_underruns", underrun_pulses, exp_underruns);

    // Underrun
    csn_low();
    send_word("t3", 16'h00FF, 1'b1, 1'b0, '0);
    checkOutput("t3_underruns", underrun_pulses, exp_underruns);
    checkOutput("t3_rx_data", 32'(bus.rx_data), 32'(exp_last_rx));

    // Truncated frame
    csn_low();
    e = model_load();
    applyStimulus(DW'($urandom), 7, 1'b1, g);
    checkOutput("t4_rx_count", rx_pulses, exp_rx);
    checkOutput("t4_rx_data", 32'(bus.rx_data), 32'(exp_last_rx));
`ifdef SPI_SLAVE_FRAME_ERR_EN
    exp_frame_err++;
    checkOutput("t4_frame_err", frame_err_pulses, exp_frame_err);
`endif
    push_tx(DW'($urandom));
    csn_low();
    send_word("t4", 16'h1234, 1'b1, 1'b0, '0);

    // Reset mid-frame
    csn_low();
    e = model_load();
    push_tx(DW'($urandom));
    applyStimulus(DW'($urandom), 5, 1'b0, g);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("t5_miso", 32'(bus.s_miso), 32'd0);
    checkOutput("t5_oe", 32'(bus.s_miso_oe), 32'd0);
    checkOutput("t5_tx_ready", 32'(bus.tx_ready), 32'd1);
    checkOutput("t5_rx_data", 32'(bus.rx_data), 32'd0);
    checkOutput("t5_rx_valid", 32'(bus.rx_valid), 32'd0);
    checkOutput("t5_underrun", 32'(bus.tx_underrun), 32'd0);
    reset       = 1'b0;
    m_full      = 1'b0;
    exp_last_rx = '0;
    repeat (2 * HALF) @(negedge clk);
    checkOutput("t5_oe_held", 32'(bus.s_miso_oe), 32'd0);
    bus.s_csn = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    push_tx(DW'($urandom));
    csn_low();
    send_word("t5", 16'h5A5A, 1'b1, 1'b0, '0);
    checkOutput("t5_rx_count", rx_pulses, exp_rx);

    // Handshake in the LOAD cycle with an empty buffer
    @(negedge clk);
    bus.s_csn = 1'b0;
    repeat (SYNC + 1) @(posedge clk);
    @(negedge clk);
    bus.tx_data  = 16'h7777;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    e      = model_load();
    m_buf  = 16'h7777;
    m_full = 1'b1;
    checkOutput("t6_tx_ready", 32'(bus.tx_ready), 32'd0);
    repeat (HALF) @(negedge clk);
    applyStimulus(16'h0F0F, DW, 1'b1, g);
    checkOutput("t6a_miso", {16'h0, g}, {16'h0, e});
    exp_rx++;
    exp_last_rx = 16'h0F0F;
    check_rx("t6a_rx", 16'h0F0F);
    checkOutput("t6_underruns", underrun_pulses, exp_underruns);
    csn_low();
    send_word("t6b", 16'hF0F0, 1'b1, 1'b0, '0);

    // Randomized frames
    for (int f = 0; f < 4; f++) begin
      if (!m_full && $urandom_range(0, 1) == 1) push_tx(DW'($urandom));
      csn_low();
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++)
        send_word("rnd", DW'($urandom), (w == nw - 1), ($urandom_range(0, 1) == 1),
                  DW'($urandom));
    end

    checkOutput("end_rx_count", rx_pulses, exp_rx);
    checkOutput("end_rx_leftover", rx_q.size(), 0);
    checkOutput("end_underruns", underrun_pulses, exp_underruns);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    checkOutput("end_frame_err", frame_err_pulses, exp_frame_err);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
